// File: rtl/uc_pkg.sv
// rtl/uc_pkg.sv - shared opcode, immediate-select and forward-select codes for uc_pipe
package uc_pkg;

  localparam int OPCODE_W_DEF = 7;
  localparam int REG_AW_DEF   = 5;
  localparam int IMMSEL_W_DEF = 3;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } immsel_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_e;

endpackage

// File: rtl/uc_decode.sv
// rtl/uc_decode.sv - combinational ID opcode decode into controls and source-register usage
module uc_decode
  import uc_pkg::*;
#(
  parameter int OPCODE_W = OPCODE_W_DEF,
  parameter int IMMSEL_W = IMMSEL_W_DEF
) (
  input  logic [OPCODE_W-1:0] opcode,
  output logic [IMMSEL_W-1:0] immsel,
  output logic                known,
  output logic                uses_rs1,
  output logic                uses_rs2,
  output logic                branch,
  output logic                jump,
  output logic                jumplink,
  output logic                alusrc,
  output logic                luitoreg,
  output logic                memw,
  output logic                memtoreg,
  output logic                regw
);

  always_comb begin
    immsel   = IMMSEL_W'(IMM_I);
    known    = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    branch   = 1'b0;
    jump     = 1'b0;
    jumplink = 1'b0;
    alusrc   = 1'b0;
    luitoreg = 1'b0;
    memw     = 1'b0;
    memtoreg = 1'b0;
    regw     = 1'b0;
    case (opcode)
      OP_R: begin
        known = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; regw = 1'b1;
      end
      OP_IMM: begin
        known = 1'b1; uses_rs1 = 1'b1; alusrc = 1'b1; regw = 1'b1;
      end
      OP_LOAD: begin
        known = 1'b1; uses_rs1 = 1'b1; alusrc = 1'b1; memtoreg = 1'b1; regw = 1'b1;
      end
      OP_STORE: begin
        immsel = IMMSEL_W'(IMM_S);
        known = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; alusrc = 1'b1; memw = 1'b1;
      end
      OP_BRANCH: begin
        immsel = IMMSEL_W'(IMM_B);
        known = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; branch = 1'b1;
      end
      OP_LUI: begin
        immsel = IMMSEL_W'(IMM_U);
        known = 1'b1; luitoreg = 1'b1; regw = 1'b1;
      end
      OP_JAL: begin
        immsel = IMMSEL_W'(IMM_J);
        known = 1'b1; jump = 1'b1; jumplink = 1'b1; regw = 1'b1;
      end
      OP_JALR: begin
        known = 1'b1; uses_rs1 = 1'b1; jump = 1'b1; jumplink = 1'b1; alusrc = 1'b1; regw = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/uc_pipe.sv
// rtl/uc_pipe.sv - pipelined control unit: ID decode, EX/MEM/WB control registers, stall and flush
// FORWARD_EN adds fwd_a/fwd_b selects and restricts stalling to load-use.
module uc_pipe
  import uc_pkg::*;
#(
  parameter int OPCODE_W = OPCODE_W_DEF,
  parameter int REG_AW   = REG_AW_DEF,
  parameter int IMMSEL_W = IMMSEL_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [OPCODE_W-1:0] id_opcode,
  input  logic [REG_AW-1:0]   id_rd,
  input  logic [REG_AW-1:0]   id_rs1,
  input  logic [REG_AW-1:0]   id_rs2,
  input  logic                ex_redirect,
  output logic [IMMSEL_W-1:0] ImmSel,
  output logic                stall,
  output logic                flush_ifid,
  output logic                ex_valid,
  output logic                ex_branch,
  output logic                ex_jump,
  output logic                ex_jumplink,
  output logic                ex_ALUsrc,
  output logic                ex_LUItoReg,
  output logic [REG_AW-1:0]   ex_rd,
  output logic                mem_valid,
  output logic                mem_MemW,
  output logic                mem_memtoreg,
  output logic [REG_AW-1:0]   mem_rd,
  output logic                wb_valid,
  output logic                wb_RegW,
  output logic                wb_memtoreg,
  output logic [REG_AW-1:0]   wb_rd
`ifdef FORWARD_EN
 ,output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b
`endif
);

  logic dec_known, dec_u1, dec_u2;
  logic dec_branch, dec_jump, dec_jumplink, dec_alusrc, dec_lui, dec_memw, dec_memtoreg, dec_regw;

  uc_decode #(.OPCODE_W(OPCODE_W), .IMMSEL_W(IMMSEL_W)) u_decode (
    .opcode   (id_opcode),
    .immsel   (ImmSel),
    .known    (dec_known),
    .uses_rs1 (dec_u1),
    .uses_rs2 (dec_u2),
    .branch   (dec_branch),
    .jump     (dec_jump),
    .jumplink (dec_jumplink),
    .alusrc   (dec_alusrc),
    .luitoreg (dec_lui),
    .memw     (dec_memw),
    .memtoreg (dec_memtoreg),
    .regw     (dec_regw)
  );

  logic              ex_v, ex_branch_q, ex_jump_q, ex_jumplink_q, ex_alusrc_q, ex_lui_q;
  logic              ex_memw_q, ex_memtoreg_q, ex_regw_q;
  logic [REG_AW-1:0] ex_rd_q;
  logic              mem_v, mem_memw_q, mem_memtoreg_q, mem_regw_q;
  logic [REG_AW-1:0] mem_rd_q;
  logic              wb_v, wb_regw_q, wb_memtoreg_q;
  logic [REG_AW-1:0] wb_rd_q;

  function automatic logic rd_hit(input logic v, input logic regw,
                                  input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] rs);
    return v && regw && (rd != '0) && (rd == rs);
  endfunction

  logic id_use1, id_use2, load_use, hazard;
  assign id_use1  = id_valid & dec_u1;
  assign id_use2  = id_valid & dec_u2;
  assign load_use = ex_memtoreg_q &
                    ((id_use1 & rd_hit(ex_v, ex_regw_q, ex_rd_q, id_rs1)) |
                     (id_use2 & rd_hit(ex_v, ex_regw_q, ex_rd_q, id_rs2)));

`ifdef FORWARD_EN
  assign hazard = load_use;
`else
  // Without forwarding any in-flight producer blocks the consumer until it leaves WB.
  logic raw1, raw2;
  assign raw1 = rd_hit(ex_v, ex_regw_q, ex_rd_q, id_rs1) |
                rd_hit(mem_v, mem_regw_q, mem_rd_q, id_rs1) |
                rd_hit(wb_v, wb_regw_q, wb_rd_q, id_rs1);
  assign raw2 = rd_hit(ex_v, ex_regw_q, ex_rd_q, id_rs2) |
                rd_hit(mem_v, mem_regw_q, mem_rd_q, id_rs2) |
                rd_hit(wb_v, wb_regw_q, wb_rd_q, id_rs2);
  assign hazard = load_use | (id_use1 & raw1) | (id_use2 & raw2);
`endif

  assign stall      = ~rst & ~ex_redirect & hazard;
  assign flush_ifid = ex_redirect;

`ifdef FORWARD_EN
  logic [REG_AW-1:0] ex_rs1_q, ex_rs2_q;

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
    if (rd_hit(mem_v, mem_regw_q, mem_rd_q, rs)) return FWD_MEM;
    if (rd_hit(wb_v, wb_regw_q, wb_rd_q, rs))    return FWD_WB;
    return FWD_RF;
  endfunction

  assign fwd_a = fwd_sel(ex_rs1_q);
  assign fwd_b = fwd_sel(ex_rs2_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_rs1_q <= '0;
      ex_rs2_q <= '0;
    end else begin
      ex_rs1_q <= id_rs1;
      ex_rs2_q <= id_rs2;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_v <= 1'b0; ex_branch_q <= 1'b0; ex_jump_q <= 1'b0; ex_jumplink_q <= 1'b0;
      ex_alusrc_q <= 1'b0; ex_lui_q <= 1'b0; ex_memw_q <= 1'b0; ex_memtoreg_q <= 1'b0;
      ex_regw_q <= 1'b0; ex_rd_q <= '0;
      mem_v <= 1'b0; mem_memw_q <= 1'b0; mem_memtoreg_q <= 1'b0; mem_regw_q <= 1'b0;
      mem_rd_q <= '0;
      wb_v <= 1'b0; wb_regw_q <= 1'b0; wb_memtoreg_q <= 1'b0; wb_rd_q <= '0;
    end else begin
      // Unknown opcodes, flushes and stalls all enter EX as bubbles.
      ex_v          <= id_valid & dec_known & ~ex_redirect & ~stall;
      ex_branch_q   <= dec_branch;
      ex_jump_q     <= dec_jump;
      ex_jumplink_q <= dec_jumplink;
      ex_alusrc_q   <= dec_alusrc;
      ex_lui_q      <= dec_lui;
      ex_memw_q     <= dec_memw;
      ex_memtoreg_q <= dec_memtoreg;
      ex_regw_q     <= dec_regw;
      ex_rd_q       <= id_rd;
      mem_v          <= ex_v;
      mem_memw_q     <= ex_memw_q;
      mem_memtoreg_q <= ex_memtoreg_q;
      mem_regw_q     <= ex_regw_q;
      mem_rd_q       <= ex_rd_q;
      wb_v          <= mem_v;
      wb_regw_q     <= mem_regw_q;
      wb_memtoreg_q <= mem_memtoreg_q;
      wb_rd_q       <= mem_rd_q;
    end
  end

  assign ex_valid     = ex_v;
  assign ex_branch    = ex_v & ex_branch_q;
  assign ex_jump      = ex_v & ex_jump_q;
  assign ex_jumplink  = ex_v & ex_jumplink_q;
  assign ex_ALUsrc    = ex_v & ex_alusrc_q;
  assign ex_LUItoReg  = ex_v & ex_lui_q;
  assign ex_rd        = ex_rd_q;
  assign mem_valid    = mem_v;
  assign mem_MemW     = mem_v & mem_memw_q;
  assign mem_memtoreg = mem_v & mem_memtoreg_q;
  assign mem_rd       = mem_rd_q;
  assign wb_valid     = wb_v;
  assign wb_RegW      = wb_v & wb_regw_q;
  assign wb_memtoreg  = wb_v & wb_memtoreg_q;
  assign wb_rd        = wb_rd_q;

endmodule

// File: tb/tb_uc_pipe.sv
// tb/tb_uc_pipe.sv - scoreboard bench for uc_pipe; build with FORWARD_EN defined to cover forwarding
module tb_uc_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [6:0] id_opcode;
  logic [4:0] id_rd, id_rs1, id_rs2;
  logic       ex_redirect;
  logic [2:0] ImmSel;
  logic       stall, flush_ifid;
  logic       ex_valid, ex_branch, ex_jump, ex_jumplink, ex_ALUsrc, ex_LUItoReg;
  logic [4:0] ex_rd;
  logic       mem_valid, mem_MemW, mem_memtoreg;
  logic [4:0] mem_rd;
  logic       wb_valid, wb_RegW, wb_memtoreg;
  logic [4:0] wb_rd;
`ifdef FORWARD_EN
  logic [1:0] fwd_a, fwd_b;
`endif

  uc_pipe dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_rd(id_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_redirect(ex_redirect), .ImmSel(ImmSel),
    .stall(stall), .flush_ifid(flush_ifid), .ex_valid(ex_valid), .ex_branch(ex_branch),
    .ex_jump(ex_jump), .ex_jumplink(ex_jumplink), .ex_ALUsrc(ex_ALUsrc),
    .ex_LUItoReg(ex_LUItoReg), .ex_rd(ex_rd), .mem_valid(mem_valid), .mem_MemW(mem_MemW),
    .mem_memtoreg(mem_memtoreg), .mem_rd(mem_rd), .wb_valid(wb_valid), .wb_RegW(wb_RegW),
    .wb_memtoreg(wb_memtoreg), .wb_rd(wb_rd)
`ifdef FORWARD_EN
   ,.fwd_a(fwd_a), .fwd_b(fwd_b)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ok, u1, u2, branch, jump, jumplink, alusrc, lui, memw, memtoreg, regw;
    logic [2:0] imm;
  } dec_t;

  typedef struct packed {
    logic       v;
    dec_t       d;
    logic [4:0] rd, rs1, rs2;
  } ent_t;

  typedef struct packed {
    logic       v;
    logic [6:0] op;
    logic [4:0] rd, rs1, rs2;
    logic       redir;
  } instr_t;

  int     n_chk = 0;
  int     n_pass = 0;
  ent_t   sb[$];
  instr_t prog[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic dec_t mdec(input logic [6:0] op);
    dec_t d = '0;
    case (op)
      7'h33: begin d.ok = 1; d.u1 = 1; d.u2 = 1; d.regw = 1; end
      7'h13: begin d.ok = 1; d.u1 = 1; d.alusrc = 1; d.regw = 1; end
      7'h03: begin d.ok = 1; d.u1 = 1; d.alusrc = 1; d.memtoreg = 1; d.regw = 1; end
      7'h23: begin d.ok = 1; d.u1 = 1; d.u2 = 1; d.alusrc = 1; d.memw = 1; d.imm = 3'd1; end
      7'h63: begin d.ok = 1; d.u1 = 1; d.u2 = 1; d.branch = 1; d.imm = 3'd2; end
      7'h37: begin d.ok = 1; d.lui = 1; d.regw = 1; d.imm = 3'd3; end
      7'h6F: begin d.ok = 1; d.jump = 1; d.jumplink = 1; d.regw = 1; d.imm = 3'd4; end
      7'h67: begin d.ok = 1; d.u1 = 1; d.jump = 1; d.jumplink = 1; d.alusrc = 1; d.regw = 1; end
      default: ;
    endcase
    return d;
  endfunction

  function automatic logic writes(input ent_t e, input logic [4:0] rs);
    return e.v && e.d.regw && (e.rd != 5'd0) && (e.rd == rs);
  endfunction

  // sb[2] is EX, sb[1] is MEM, sb[0] is WB.
  function automatic logic model_stall(input instr_t in, input dec_t d);
    logic h1, h2;
    if (!in.v || in.redir) return 1'b0;
`ifdef FORWARD_EN
    h1 = sb[2].d.memtoreg && writes(sb[2], in.rs1);
    h2 = sb[2].d.memtoreg && writes(sb[2], in.rs2);
`else
    h1 = writes(sb[2], in.rs1) || writes(sb[1], in.rs1) || writes(sb[0], in.rs1);
    h2 = writes(sb[2], in.rs2) || writes(sb[1], in.rs2) || writes(sb[0], in.rs2);
`endif
    return (d.u1 && h1) || (d.u2 && h2);
  endfunction

`ifdef FORWARD_EN
  function automatic logic [1:0] mfwd(input logic [4:0] rs);
    if (writes(sb[1], rs)) return 2'b10;
    if (writes(sb[0], rs)) return 2'b01;
    return 2'b00;
  endfunction
`endif

  task automatic cmp_stages();
    ent_t x, m, w;
    x = sb[2]; m = sb[1]; w = sb[0];
    chk("ex_valid", ex_valid, x.v);
    chk("ex_branch", ex_branch, x.v & x.d.branch);
    chk("ex_jump", ex_jump, x.v & x.d.jump);
    chk("ex_jumplink", ex_jumplink, x.v & x.d.jumplink);
    chk("ex_ALUsrc", ex_ALUsrc, x.v & x.d.alusrc);
    chk("ex_LUItoReg", ex_LUItoReg, x.v & x.d.lui);
    if (x.v) chk("ex_rd", ex_rd, x.rd);
    chk("mem_valid", mem_valid, m.v);
    chk("mem_MemW", mem_MemW, m.v & m.d.memw);
    chk("mem_memtoreg", mem_memtoreg, m.v & m.d.memtoreg);
    if (m.v) chk("mem_rd", mem_rd, m.rd);
    chk("wb_valid", wb_valid, w.v);
    chk("wb_RegW", wb_RegW, w.v & w.d.regw);
    chk("wb_memtoreg", wb_memtoreg, w.v & w.d.memtoreg);
    if (w.v) chk("wb_rd", wb_rd, w.rd);
`ifdef FORWARD_EN
    chk("fwd_a", fwd_a, mfwd(x.rs1));
    chk("fwd_b", fwd_b, mfwd(x.rs2));
`endif
  endtask

  task automatic clear_sb();
    sb.delete();
    repeat (3) sb.push_back('0);
  endtask

  // Called #1 after a posedge: drive, check ID outputs, clock, then compare stages.
  task automatic step(input instr_t in, input logic r, output logic st);
    dec_t d;
    ent_t e;
    logic exp_st;
    rst = r; id_valid = in.v; id_opcode = in.op; id_rd = in.rd;
    id_rs1 = in.rs1; id_rs2 = in.rs2; ex_redirect = in.redir;
    d = mdec(in.op);
    exp_st = r ? 1'b0 : model_stall(in, d);
    #2;
    chk("ImmSel", ImmSel, d.imm);
    chk("stall", stall, exp_st);
    chk("flush_ifid", flush_ifid, in.redir);
    e.v = in.v & d.ok & ~in.redir & ~exp_st;
    e.d = d; e.rd = in.rd; e.rs1 = in.rs1; e.rs2 = in.rs2;
    @(posedge clk); #1;
    if (r) clear_sb();
    else begin
      sb.push_back(e);
      void'(sb.pop_front());
    end
    cmp_stages();
    st = exp_st;
  endtask

  task automatic put(input logic v, input logic [6:0] op, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic redir);
    instr_t t;
    t.v = v; t.op = op; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2; t.redir = redir;
    prog.push_back(t);
  endtask

  task automatic nops(input int n);
    repeat (n) put(1'b0, 7'h00, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  // Stalled instructions are re-presented until accepted; bounded by a cycle budget.
  task automatic run_prog(input string tag, input int exp_stalls);
    int   i = 0;
    int   cyc = 0;
    int   nst = 0;
    logic st;
    while (i < prog.size() && cyc < 200) begin
      step(prog[i], 1'b0, st);
      if (st) nst++;
      else i++;
      cyc++;
    end
    chk({tag, "_done"}, i, prog.size());
    chk({tag, "_stalls"}, nst, exp_stalls);
    prog.delete();
  endtask

  initial begin
    instr_t nop;
    logic   st;
    int     fwd;
`ifdef FORWARD_EN
    fwd = 1;
`else
    fwd = 0;
`endif
    nop = '0;
    rst = 1'b1; id_valid = 1'b0; id_opcode = '0; id_rd = '0; id_rs1 = '0; id_rs2 = '0;
    ex_redirect = 1'b0;
    clear_sb();
    @(posedge clk); #1;
    step(nop, 1'b1, st);
    chk("rst_ex_rd", ex_rd, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_wb_rd", wb_rd, 0);

    put(1, 7'd19, 5'd1, 5'd2, 5'd0, 0);
    put(1, 7'd35, 5'd0, 5'd2, 5'd3, 0);
    put(1, 7'd111, 5'd4, 5'd0, 5'd0, 0);
    nops(3);
    run_prog("basic", 0);

    put(1, 7'd3, 5'd5, 5'd6, 5'd0, 0);
    put(1, 7'd51, 5'd7, 5'd5, 5'd8, 0);
    nops(3);
    run_prog("load_use", fwd ? 1 : 3);

    put(1, 7'd19, 5'd0, 5'd1, 5'd0, 0);
    put(1, 7'd3, 5'd0, 5'd1, 5'd0, 0);
    put(1, 7'd51, 5'd9, 5'd0, 5'd0, 0);
    nops(3);
    run_prog("x0", 0);

    put(1, 7'd3, 5'd10, 5'd0, 5'd0, 0);
    put(1, 7'd51, 5'd11, 5'd10, 5'd0, 1);
    nops(3);
    run_prog("redirect", 0);

    put(1, 7'h7F, 5'd3, 5'd1, 5'd2, 0);
    nops(3);
    run_prog("unknown", 0);

    put(1, 7'd19, 5'd11, 5'd0, 5'd0, 0);
    put(1, 7'd19, 5'd12, 5'd0, 5'd0, 0);
    put(1, 7'd51, 5'd13, 5'd12, 5'd11, 0);
    nops(3);
    run_prog("raw", fwd ? 0 : 3);

    put(1, 7'd19, 5'd14, 5'd0, 5'd0, 0);
    put(1, 7'd55, 5'd15, 5'd0, 5'd0, 0);
    put(1, 7'd35, 5'd0, 5'd0, 5'd0, 0);
    run_prog("fill", 0);
    chk("pre_rst_valid", {ex_valid, mem_valid, wb_valid}, 3'b111);
    step(nop, 1'b1, st);
    chk("mid_rst_valid", {ex_valid, mem_valid, wb_valid}, 3'b000);
    chk("mid_rst_ctrl", {ex_ALUsrc, ex_LUItoReg, mem_MemW, wb_RegW}, 4'b0000);
    chk("mid_rst_rd", {ex_rd, mem_rd, wb_rd}, 15'd0);
    step(nop, 1'b0, st);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
